mem_arbiter: RTL and testbench

Two-port arbiter that shares the single byte-wide memory between the cpu core (port 0) and a second requester such as a program loader or debug port (port 1). Each port gets a one-entry request latch, so a single-cycle write strobe is never lost. A round-robin grant selects which latched request drives the memory port. The block sits between the requesters and the memory model, and presents the same addr/data/read_en/write_en/ready handshake on both sides.

---
 rtl/mem_arbiter_pkg.sv | 44 ++++
 rtl/mem_arbiter_if.sv | 30 +++
 rtl/mem_arbiter_port.sv | 101 ++++++++++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared types for the two-port memory arbiter.
//   port_state_t : per-port request FSM (IDLE/PEND/BUSY/HOLD)
//   mem_state_t  : memory-side FSM (M_IDLE/M_ACCESS)
//   op_t         : latched operation (OP_READ/OP_WRITE)
//   PORT0/PORT1  : port index constants used for grant bookkeeping
//   rr_pick()    : round-robin choice between the two pending ports
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    BUSY = 2'd2,
    HOLD = 2'd3
  } port_state_t;

  typedef enum logic {
    M_IDLE   = 1'b0,
    M_ACCESS = 1'b1
  } mem_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // On a tie the port that did not win last time gets the grant; a lone
  // pending port always wins regardless of history.
  function automatic logic rr_pick(input logic pend0, input logic pend1,
                                   input logic last_grant);
    logic pick;
    if (pend0 && pend1) begin
      pick = (last_grant == PORT0) ? PORT1 : PORT0;
    end else if (pend1) begin
      pick = PORT1;
    end else begin
      pick = PORT0;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arb_if: byte-wide memory handshake bundle, used both between a
// requester and the arbiter and between the arbiter and the memory.
//   addr, data_in, read_en, write_en : master -> slave (request, write data)
//   data_out, ready, err             : slave -> master (read data, completion)
// modport master: the side that issues requests.
// modport slave : the side that services them.
interface mem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8
);

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic              read_en;
  logic              write_en;
  logic [DATA_W-1:0] data_out;
  logic              ready;
  logic              err;

  modport master (
    output addr, data_in, read_en, write_en,
    input  data_out, ready, err
  );

  modport slave (
    input  addr, data_in, read_en, write_en,
    output data_out, ready, err
  );

endinterface

// File: rtl/mem_arbiter_port.sv
// mem_arb_port: one requester port of the arbiter.
// Holds a one-entry request latch, the IDLE/PEND/BUSY/HOLD FSM and the
// registered ready / data_out / err outputs seen by the requester.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   req         : requester-facing handshake (slave side)
//   grant       : arbiter picks this port this cycle (only while PEND)
//   done        : the in-flight memory access for this port finishes
//   done_err    : the finishing access was aborted by the watchdog
//   mem_rdata   : memory read data, captured on a successful read
//   pending     : port is waiting for a grant
//   lat_addr/lat_data/lat_op : latched request presented to the arbiter
module mem_arb_port
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  mem_arb_if.slave          req,
  input  logic              grant,
  input  logic              done,
  input  logic              done_err,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pending,
  output logic [ADDR_W-1:0] lat_addr,
  output logic [DATA_W-1:0] lat_data,
  output op_t               lat_op
);

  port_state_t       state;
  port_state_t       next_state;
  logic              capture;
  logic              complete;
  logic              ready_q;
  logic              err_q;
  logic [DATA_W-1:0] data_out_q;

  // Enables only matter in IDLE; PEND/BUSY/HOLD ignore them so a requester
  // still holding its enable after ready never causes a second access.
  assign capture  = (state == IDLE) && (req.read_en || req.write_en);
  assign complete = (state == BUSY) && done;
  assign pending  = (state == PEND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (capture)  next_state = PEND;
      PEND: if (grant)    next_state = BUSY;
      BUSY: if (complete) next_state = HOLD;
      HOLD:               next_state = IDLE;
      default:            next_state = IDLE;
    endcase
  end

  // Write wins when both enables are high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_addr <= '0;
      lat_data <= '0;
      lat_op   <= OP_READ;
    end else if (capture) begin
      lat_addr <= req.addr;
      lat_data <= req.data_in;
      lat_op   <= req.write_en ? OP_WRITE : OP_READ;
    end
  end

  // ready/err last exactly the HOLD cycle; data_out is only refreshed by a
  // read that really completed, so an aborted access leaves it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      data_out_q <= '0;
    end else if (complete) begin
      ready_q <= 1'b1;
      err_q   <= done_err;
      if (!done_err && (lat_op == OP_READ)) begin
        data_out_q <= mem_rdata;
      end
    end else if (state == HOLD) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end
  end

  assign req.ready    = ready_q;
  assign req.err      = err_q;
  assign req.data_out = data_out_q;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide memory between two requesters
// (port 0: cpu core, port 1: loader/debug) with a round-robin grant.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   p0, p1   : requester handshakes (slave side of mem_arb_if)
//   mem      : memory handshake (master side of mem_arb_if)
// Optional feature: define MEM_ARB_TIMEOUT_EN to enable a watchdog that
// aborts an access after TIMEOUT_CYCLES cycles without mem.ready and
// completes the port with err=1. Without it, err stays 0 and an access
// waits for mem.ready indefinitely.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic      clk,
  input  logic      rst,
  mem_arb_if.slave  p0,
  mem_arb_if.slave  p1,
  mem_arb_if.master mem
);

  mem_state_t        m_state;
  mem_state_t        m_next;
  logic              last_grant;
  logic              grant_valid;
  logic              grant_sel;
  logic              access_end;
  logic              timeout;

  logic              p0_pend;
  logic              p1_pend;
  logic [ADDR_W-1:0] p0_lat_addr;
  logic [ADDR_W-1:0] p1_lat_addr;
  logic [DATA_W-1:0] p0_lat_data;
  logic [DATA_W-1:0] p1_lat_data;
  op_t               p0_lat_op;
  op_t               p1_lat_op;
  op_t               sel_op;

  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_rd_q;
  logic              mem_wr_q;

  mem_arb_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port0 (
    .clk       (clk),
    .rst       (rst),
    .req       (p0),
    .grant     (grant_valid && (grant_sel == PORT0)),
    .done      (access_end && (last_grant == PORT0)),
    .done_err  (timeout),
    .mem_rdata (mem.data_out),
    .pending   (p0_pend),
    .lat_addr  (p0_lat_addr),
    .lat_data  (p0_lat_data),
    .lat_op    (p0_lat_op)
  );

  mem_arb_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port1 (
    .clk       (clk),
    .rst       (rst),
    .req       (p1),
    .grant     (grant_valid && (grant_sel == PORT1)),
    .done      (access_end && (last_grant == PORT1)),
    .done_err  (timeout),
    .mem_rdata (mem.data_out),
    .pending   (p1_pend),
    .lat_addr  (p1_lat_addr),
    .lat_data  (p1_lat_data),
    .lat_op    (p1_lat_op)
  );

  // Grants are only issued from M_IDLE, which guarantees one idle cycle
  // between consecutive accesses. last_grant doubles as the owner of the
  // access in flight, so it also routes the completion.
  assign grant_valid = (m_state == M_IDLE) && (p0_pend || p1_pend);
  assign grant_sel   = rr_pick(p0_pend, p1_pend, last_grant);
  assign sel_op      = (grant_sel == PORT1) ? p1_lat_op : p0_lat_op;
  assign access_end  = (m_state == M_ACCESS) && (mem.ready || timeout);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt;

  // The counter equals the number of M_ACCESS edges already passed, so a
  // hit at TIMEOUT_CYCLES-1 ends the strobe after exactly TIMEOUT_CYCLES
  // cycles. A real mem.ready on the same edge takes precedence.
  assign timeout = (m_state == M_ACCESS) && !mem.ready &&
                   (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if ((m_state == M_ACCESS) && !access_end) begin
      wd_cnt <= wd_cnt + 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= M_IDLE;
    end else begin
      m_state <= m_next;
    end
  end

  // mem.ready seen in M_IDLE has no effect.
  always_comb begin
    m_next = m_state;
    case (m_state)
      M_IDLE:   if (grant_valid) m_next = M_ACCESS;
      M_ACCESS: if (access_end)  m_next = M_IDLE;
      default:                   m_next = M_IDLE;
    endcase
  end

  // Memory outputs are registered so the strobes rise on the grant edge and
  // fall on the completion edge; the bus returns to all-zero when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      last_grant  <= PORT1;
    end else if (grant_valid) begin
      last_grant  <= grant_sel;
      mem_addr_q  <= (grant_sel == PORT1) ? p1_lat_addr : p0_lat_addr;
      mem_wdata_q <= (grant_sel == PORT1) ? p1_lat_data : p0_lat_data;
      mem_rd_q    <= (sel_op == OP_READ);
      mem_wr_q    <= (sel_op == OP_WRITE);
    end else if (access_end) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
    end
  end

  assign mem.addr     = mem_addr_q;
  assign mem.data_in  = mem_wdata_q;
  assign mem.read_en  = mem_rd_q;
  assign mem.write_en = mem_wr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
// Inputs change and outputs are sampled on the falling clock edge; the
// memory side is answered by hand with a chosen latency and read value.
// Define MEM_ARB_TIMEOUT_EN to include the watchdog abort scenario
// (the DUT is built with TIMEOUT_CYCLES = 4).
module tb_mem_arbiter;

  logic clk;
  logic rst;

  mem_arb_if #(.ADDR_W(32), .DATA_W(8)) p0_if ();
  mem_arb_if #(.ADDR_W(32), .DATA_W(8)) p1_if ();
  mem_arb_if #(.ADDR_W(32), .DATA_W(8)) mem_if ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(8), .TIMEOUT_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .p0  (p0_if),
    .p1  (p1_if),
    .mem (mem_if)
  );

  int checks = 0;
  int errors = 0;

  int rd_hi = 0;
  int wr_hi = 0;
  int acc_starts = 0;
  int p0_pulses = 0;
  int p1_pulses = 0;
  logic prev_stb = 1'b0;

  int s_rd, s_wr, s_acc, s_p0, s_p1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-cycle activity counters, used as before/after snapshots.
  always @(negedge clk) begin
    if (mem_if.read_en) rd_hi++;
    if (mem_if.write_en) wr_hi++;
    if ((mem_if.read_en || mem_if.write_en) && !prev_stb) acc_starts++;
    prev_stb = mem_if.read_en || mem_if.write_en;
    if (p0_if.ready) p0_pulses++;
    if (p1_if.ready) p1_pulses++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic port, input logic rd,
                               input logic wr, input logic [31:0] addr,
                               input logic [7:0] data);
    if (port == 1'b0) begin
      p0_if.read_en  = rd;
      p0_if.write_en = wr;
      p0_if.addr     = addr;
      p0_if.data_in  = data;
    end else begin
      p1_if.read_en  = rd;
      p1_if.write_en = wr;
      p1_if.addr     = addr;
      p1_if.data_in  = data;
    end
  endtask

  task automatic waitStrobe(input string tag);
    int n = 0;
    while (!(mem_if.read_en || mem_if.write_en) && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(mem_if.read_en || mem_if.write_en), 32'd1);
  endtask

  // Called on the first negedge with the strobe high; mem_ready is seen by
  // the DUT exactly lat cycles after the strobe rose. Returns on the negedge
  // inside the resulting ready pulse.
  task automatic memAck(input int lat, input logic [7:0] rdata);
    repeat (lat - 1) @(negedge clk);
    mem_if.data_out = rdata;
    mem_if.ready    = 1'b1;
    @(negedge clk);
    mem_if.ready    = 1'b0;
    mem_if.data_out = 8'h00;
  endtask

  task automatic pulseRead(input logic port, input logic [31:0] addr);
    applyStimulus(port, 1'b1, 1'b0, addr, 8'h00);
    @(negedge clk);
    applyStimulus(port, 1'b0, 1'b0, 32'h0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed 0 expected 1");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 8'h00);
    mem_if.data_out = 8'h00;
    mem_if.ready    = 1'b0;
    mem_if.err      = 1'b0;
    repeat (2) @(negedge clk);

    checkOutput("rst_mem_rd", 32'(mem_if.read_en), 32'd0);
    checkOutput("rst_mem_wr", 32'(mem_if.write_en), 32'd0);
    checkOutput("rst_mem_addr", mem_if.addr, 32'h0);
    checkOutput("rst_p0_ready", 32'(p0_if.ready), 32'd0);
    checkOutput("rst_p1_ready", 32'(p1_if.ready), 32'd0);
    checkOutput("rst_p0_data", 32'(p0_if.data_out), 32'h0);
    checkOutput("rst_p1_err", 32'(p1_if.err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Port 0 read of 0x1A, memory answers 0x41 after 2 cycles.
    s_rd = rd_hi; s_p0 = p0_pulses; s_p1 = p1_pulses;
    pulseRead(1'b0, 32'h1A);
    waitStrobe("t1_strobe");
    checkOutput("t1_mem_addr", mem_if.addr, 32'h1A);
    memAck(2, 8'h41);
    checkOutput("t1_p0_ready", 32'(p0_if.ready), 32'd1);
    checkOutput("t1_p0_data", 32'(p0_if.data_out), 32'h41);
    checkOutput("t1_p0_err", 32'(p0_if.err), 32'd0);
    checkOutput("t1_p1_ready", 32'(p1_if.ready), 32'd0);
    checkOutput("t1_p1_data", 32'(p1_if.data_out), 32'h0);
    checkOutput("t1_mem_rd_low", 32'(mem_if.read_en), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("t1_rd_cycles", 32'(rd_hi - s_rd), 32'd2);
    checkOutput("t1_p0_pulses", 32'(p0_pulses - s_p0), 32'd1);
    checkOutput("t1_p1_pulses", 32'(p1_pulses - s_p1), 32'd0);
    checkOutput("t1_p0_data_held", 32'(p0_if.data_out), 32'h41);

    // Port 0 single-cycle write pulse: addr 0xAA, data 0x07, 3-cycle memory.
    s_wr = wr_hi; s_p0 = p0_pulses;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hAA, 8'h07);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
    waitStrobe("t2_strobe");
    checkOutput("t2_mem_wr", 32'(mem_if.write_en), 32'd1);
    checkOutput("t2_mem_rd", 32'(mem_if.read_en), 32'd0);
    checkOutput("t2_mem_addr", mem_if.addr, 32'hAA);
    checkOutput("t2_mem_wdata", 32'(mem_if.data_in), 32'h07);
    memAck(3, 8'hEE);
    checkOutput("t2_p0_ready", 32'(p0_if.ready), 32'd1);
    checkOutput("t2_p0_data_kept", 32'(p0_if.data_out), 32'h41);
    repeat (3) @(negedge clk);
    checkOutput("t2_wr_cycles", 32'(wr_hi - s_wr), 32'd3);
    checkOutput("t2_p0_pulses", 32'(p0_pulses - s_p0), 32'd1);
    checkOutput("t2_idle_addr", mem_if.addr, 32'h0);

    // Simultaneous reads right after reset: port 0 wins the first tie.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h20, 8'h00);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 8'h00);
    waitStrobe("t3a_strobe0");
    checkOutput("t3a_first_addr", mem_if.addr, 32'h10);
    memAck(1, 8'h55);
    checkOutput("t3a_p0_ready", 32'(p0_if.ready), 32'd1);
    checkOutput("t3a_p0_data", 32'(p0_if.data_out), 32'h55);
    checkOutput("t3a_p1_wait", 32'(p1_if.ready), 32'd0);
    waitStrobe("t3a_strobe1");
    checkOutput("t3a_second_addr", mem_if.addr, 32'h20);
    memAck(1, 8'h66);
    checkOutput("t3a_p1_ready", 32'(p1_if.ready), 32'd1);
    checkOutput("t3a_p1_data", 32'(p1_if.data_out), 32'h66);

    // A lone port-0 access makes port 0 the last grant, so the next tie
    // must go to port 1.
    pulseRead(1'b0, 32'h30);
    waitStrobe("t3b_strobe");
    memAck(1, 8'h11);
    checkOutput("t3b_p0_data", 32'(p0_if.data_out), 32'h11);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h20, 8'h00);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 8'h00);
    waitStrobe("t3c_strobe0");
    checkOutput("t3c_first_addr", mem_if.addr, 32'h20);
    memAck(1, 8'h22);
    checkOutput("t3c_p1_data", 32'(p1_if.data_out), 32'h22);
    waitStrobe("t3c_strobe1");
    checkOutput("t3c_second_addr", mem_if.addr, 32'h10);
    memAck(1, 8'h23);
    checkOutput("t3c_p0_data", 32'(p0_if.data_out), 32'h23);
    repeat (2) @(negedge clk);

    // Port 0 keeps read_en high through ready and drops it one cycle later.
    s_acc = acc_starts;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h33, 8'h00);
    waitStrobe("t4_strobe");
    memAck(2, 8'h77);
    checkOutput("t4_p0_ready", 32'(p0_if.ready), 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
    repeat (4) @(negedge clk);
    checkOutput("t4_accesses", 32'(acc_starts - s_acc), 32'd1);
    checkOutput("t4_p0_data", 32'(p0_if.data_out), 32'h77);

    // Reset in the middle of a port-1 read.
    s_p1 = p1_pulses;
    pulseRead(1'b1, 32'h44);
    waitStrobe("t5_strobe");
    rst = 1'b1;
    #1;
    checkOutput("t5_rd_async_low", 32'(mem_if.read_en), 32'd0);
    checkOutput("t5_addr_cleared", mem_if.addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("t5_no_p1_ready", 32'(p1_pulses - s_p1), 32'd0);

    // Stray mem_ready while idle must be ignored.
    s_p0 = p0_pulses; s_p1 = p1_pulses; s_acc = acc_starts;
    mem_if.data_out = 8'hFF;
    mem_if.ready    = 1'b1;
    @(negedge clk);
    mem_if.ready    = 1'b0;
    mem_if.data_out = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("t5_idle_rdy_p0", 32'(p0_pulses - s_p0), 32'd0);
    checkOutput("t5_idle_rdy_p1", 32'(p1_pulses - s_p1), 32'd0);
    checkOutput("t5_idle_rdy_acc", 32'(acc_starts - s_acc), 32'd0);

    // Normal service after the reset.
    pulseRead(1'b0, 32'h5C);
    waitStrobe("t5_post_strobe");
    checkOutput("t5_post_addr", mem_if.addr, 32'h5C);
    memAck(2, 8'h9A);
    checkOutput("t5_post_ready", 32'(p0_if.ready), 32'd1);
    checkOutput("t5_post_data", 32'(p0_if.data_out), 32'h9A);
    repeat (2) @(negedge clk);

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: watchdog aborts after 4 strobe cycles.
    begin
      int n = 0;
      s_rd = rd_hi;
      pulseRead(1'b1, 32'h66);
      waitStrobe("t6_strobe");
      while (!p1_if.ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      checkOutput("t6_p1_ready", 32'(p1_if.ready), 32'd1);
      checkOutput("t6_p1_err", 32'(p1_if.err), 32'd1);
      checkOutput("t6_p1_data", 32'(p1_if.data_out), 32'h0);
      checkOutput("t6_rd_low", 32'(mem_if.read_en), 32'd0);
      repeat (2) @(negedge clk);
      checkOutput("t6_rd_cycles", 32'(rd_hi - s_rd), 32'd4);
      checkOutput("t6_err_cleared", 32'(p1_if.err), 32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
